// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS boot path: the encoding of the
// instruction-memory loader states, the number of bytes in a word, and the
// default instruction-memory depth.
// No ports (package).
// ----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } loader_state_t;

   localparam int BYTES_PER_WORD   = 4;
   localparam int IMEM_DEPTH_WORDS = 256;

endpackage

// File: rtl/imem_byte_assembler.sv
// ----------------------------------------------------------------------------
// imem_byte_assembler
// Collects bytes MSB first into big-endian 32-bit words. On the cycle that
// carries the 4th byte, word_valid is high and word holds the complete word,
// including that byte, so the parent can register it on the same edge.
//
// Ports:
//   clk        clock
//   clear      synchronous clear of the byte index and shift register
//   in_valid   a byte is being accepted this cycle
//   in_data    the byte
//   word_valid high on the cycle the 4th byte is accepted
//   word       assembled word, valid together with word_valid
// ----------------------------------------------------------------------------
module imem_byte_assembler
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        clear,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  byte_idx;
   // Only the first three bytes need storing; the fourth is taken straight
   // from in_data so the word is available on the accepting edge.
   logic [23:0] shreg;

   assign word       = {shreg, in_data};
   assign word_valid = in_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (clear) begin
         byte_idx <= '0;
         shreg    <= '0;
      end else if (in_valid) begin
         byte_idx <= byte_idx + 2'd1;
         shreg    <= {shreg[15:0], in_data};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the instruction memory. Receives a byte stream
// (4-byte big-endian word count N, then N big-endian words), writes each word
// to consecutive word addresses starting at BASE_ADDR, and holds the core in
// reset until the image is complete.
//
// Optional build macro IMEM_LOADER_CHECKSUM_EN: after the last data word one
// extra byte is accepted and compared with the XOR of all header and data
// bytes; a match finishes the load, a mismatch ends in the error state.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      one-cycle pulse, starts a load from IDLE
//   s_valid    byte stream valid
//   s_data     byte stream data
//   s_ready    loader accepts a byte when s_valid && s_ready
//   mem_we     one-cycle instruction-memory write strobe
//   mem_addr   word-aligned byte address of the write (holds between writes)
//   mem_wdata  write data
//   cpu_rst    reset to the core, released when the load completes
//   done       load completed
//   error      load aborted (bad count or bad checksum)
// ----------------------------------------------------------------------------
module imem_loader
   import mips_pkg::*;
#(
   parameter int          MAX_WORDS = IMEM_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst,
   output logic        done,
   output logic        error
);

   loader_state_t    state;
   logic             accept;
   logic             asm_valid;
   logic             asm_clear;
   logic             word_valid;
   logic [31:0]      word;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] total;
   // Set after the last word is captured: the write cycle runs with s_ready
   // low, and DONE follows on the next edge.
   logic             fin;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       csum;
`endif

   assign accept    = s_valid && s_ready;
   assign asm_valid = accept && (state == ST_HDR || state == ST_DATA);
   // Outside header/data the assembler is held empty, so any partial word is
   // dropped whenever the load leaves those states or is reset.
   assign asm_clear = rst || !(state == ST_HDR || state == ST_DATA);

   imem_byte_assembler u_asm (
      .clk        (clk),
      .clear      (asm_clear),
      .in_valid   (asm_valid),
      .in_data    (s_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         s_ready   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= '0;
         cpu_rst   <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         word_cnt  <= '0;
         total     <= '0;
         fin       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_HDR;
                  s_ready  <= 1'b1;
                  word_cnt <= '0;
                  fin      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end
            ST_HDR: begin
               if (word_valid) begin
                  if (word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state   <= ST_CSUM;
`else
                     state   <= ST_DONE;
                     s_ready <= 1'b0;
                     done    <= 1'b1;
                     cpu_rst <= 1'b0;
`endif
                  end else if ((word >> CNT_W) != '0 || word > 32'(MAX_WORDS)) begin
                     state   <= ST_ERR;
                     s_ready <= 1'b0;
                     error   <= 1'b1;
                  end else begin
                     state   <= ST_DATA;
                     total   <= word[CNT_W-1:0];
                  end
               end
            end
            ST_DATA: begin
               if (fin) begin
                  state   <= ST_DONE;
                  done    <= 1'b1;
                  cpu_rst <= 1'b0;
               end else if (word_valid) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= word;
                  mem_addr  <= BASE_ADDR + (32'(word_cnt) << 2);
                  word_cnt  <= word_cnt + CNT_W'(1);
                  if (word_cnt == total - CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state   <= ST_CSUM;
`else
                     fin     <= 1'b1;
                     s_ready <= 1'b0;
`endif
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (accept) begin
                  s_ready <= 1'b0;
                  if (s_data == csum) begin
                     state   <= ST_DONE;
                     done    <= 1'b1;
                     cpu_rst <= 1'b0;
                  end else begin
                     state   <= ST_ERR;
                     error   <= 1'b1;
                  end
               end
            end
`endif
            default: ;  // DONE and ERR hold until rst
         endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (asm_valid) csum <= csum ^ s_data;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Table-driven load images plus
// hand-written sequences for reset mid-word, start after DONE/ERR and the
// optional checksum. Expected writes are derived from the byte stream by a
// small model and queued; a monitor pops them on every mem_we.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;
   localparam int          MAX_WORDS = 256;
   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, start, s_valid;
   logic [7:0]  s_data;
   logic        s_ready, mem_we, cpu_rst, done, error;
   logic [31:0] mem_addr, mem_wdata;

   always #5 clk = ~clk;

   imem_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst(cpu_rst), .done(done), .error(error)
   );

   typedef struct {
      string        name;
      int           len;
      logic [127:0] bytes;      // MSB-first stream
      bit           gaps;
      bit           junk;       // offer bytes before start
      int           exp_writes;
      bit           exp_done;
      bit           exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   vec_t tbl[6];
   wr_t  exp_q[$];
   int   tests = 0, fails = 0;
   int   cyc = 0, we_count = 0, last_we_cyc = -1, done_cyc = -1, rstfall_cyc = -1;
   logic done_q = 1'b0, cpu_rst_q = 1'b1;

   // stream model state
   int          m_cnt;
   logic [31:0] m_n, m_word;
   bit          m_ok;
   logic [7:0]  m_csum;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      wr_t e;
      if (mem_we) begin
         we_count    <= we_count + 1;
         last_we_cyc <= cyc;
         if (exp_q.size() == 0) check("unexpected_mem_we", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.data);
         end
      end
      if (done && !done_q) done_cyc <= cyc;
      if (!cpu_rst && cpu_rst_q) rstfall_cyc <= cyc;
      done_q    <= done;
      cpu_rst_q <= cpu_rst;
   end

   task automatic model_reset();
      exp_q.delete();
      m_cnt = 0; m_n = '0; m_word = '0; m_ok = 1'b0; m_csum = '0;
      we_count = 0; last_we_cyc = -1; done_cyc = -1; rstfall_cyc = -1;
   endtask

   task automatic model_byte(input logic [7:0] b);
      m_csum = m_csum ^ b;
      if (m_cnt < 4) m_n = {m_n[23:0], b};
      else if (m_ok) begin
         m_word = {m_word[23:0], b};
         if (((m_cnt - 4) % 4) == 3)
            exp_q.push_back('{BASE_ADDR + 32'(4 * ((m_cnt - 4) / 4)), m_word});
      end
      m_cnt++;
      if (m_cnt == 4) m_ok = (m_n != 0) && (m_n <= MAX_WORDS);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap, input bit model);
      int budget = 0;
      bit acc = 1'b0;
      s_valid = 1'b1;
      s_data  = b;
      while (!acc && budget < 20) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk); #1;
         budget++;
      end
      if (!acc) check("accept_timeout", 32'(acc), 32'd1);
      if (model) model_byte(b);
      if (gap) begin
         s_valid = 1'b0;
         s_data  = 8'hA5;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      check({tag, "_s_ready"},   32'(s_ready),  32'd0);
      check({tag, "_mem_we"},    32'(mem_we),   32'd0);
      check({tag, "_mem_addr"},  mem_addr,      BASE_ADDR);
      check({tag, "_mem_wdata"}, mem_wdata,     32'd0);
      check({tag, "_cpu_rst"},   32'(cpu_rst),  32'd1);
      check({tag, "_done"},      32'(done),     32'd0);
      check({tag, "_error"},     32'(error),    32'd0);
      @(posedge clk); #1;
   endtask

   task automatic run_vector(input int i, input bit with_reset);
      if (with_reset) do_reset();
      model_reset();
      if (tbl[i].junk) begin
         s_valid = 1'b1;
         s_data  = 8'hEE;
         repeat (3) begin
            @(negedge clk);
            check({tbl[i].name, "_idle_s_ready"}, 32'(s_ready), 32'd0);
            @(posedge clk); #1;
         end
      end
      pulse_start();
      for (int k = 0; k < tbl[i].len; k++)
         send_byte(tbl[i].bytes[127 - 8*k -: 8], tbl[i].gaps, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!tbl[i].exp_err) send_byte(m_csum, 1'b0, 1'b0);
`endif
      s_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check({tbl[i].name, "_done"},     32'(done),      32'(tbl[i].exp_done));
      check({tbl[i].name, "_error"},    32'(error),     32'(tbl[i].exp_err));
      check({tbl[i].name, "_cpu_rst"},  32'(cpu_rst),   32'(!tbl[i].exp_done));
      check({tbl[i].name, "_s_ready"},  32'(s_ready),   32'd0);
      check({tbl[i].name, "_writes"},   32'(we_count),  32'(tbl[i].exp_writes));
      check({tbl[i].name, "_q_empty"},  32'(exp_q.size()), 32'd0);
      if (tbl[i].exp_done)
         check({tbl[i].name, "_rst_fall_with_done"}, 32'(rstfall_cyc), 32'(done_cyc));
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (tbl[i].exp_writes > 0)
         check({tbl[i].name, "_done_after_last_we"}, 32'(done_cyc), 32'(last_we_cyc + 1));
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      tbl[0] = '{"two_words", 12, 128'h00000002_20080005_08000000_00000000, 1'b0, 1'b0, 2, 1'b1, 1'b0};
      tbl[1] = '{"two_words_gaps", 12, 128'h00000002_20080005_08000000_00000000, 1'b1, 1'b1, 2, 1'b1, 1'b0};
      tbl[2] = '{"zero_len", 4, 128'h00000000_00000000_00000000_00000000, 1'b0, 1'b0, 0, 1'b1, 1'b0};
      tbl[3] = '{"over_max", 4, 128'h00000101_00000000_00000000_00000000, 1'b0, 1'b0, 0, 1'b0, 1'b1};
      tbl[4] = '{"high_bit", 4, 128'h00010001_00000000_00000000_00000000, 1'b0, 1'b0, 0, 1'b0, 1'b1};
      tbl[5] = '{"three_words", 16, 128'h00000003_DEADBEEF_01234567_89ABCDEF, 1'b1, 1'b0, 3, 1'b1, 1'b0};

      do_reset();
      check_reset_outputs("por");

      for (int i = 0; i < 6; i++) run_vector(i, 1'b1);

      // Count exactly MAX_WORDS is accepted: loader stays ready in DATA.
      do_reset();
      model_reset();
      pulse_start();
      send_byte(8'h00, 1'b0, 1'b1); send_byte(8'h00, 1'b0, 1'b1);
      send_byte(8'h01, 1'b0, 1'b1); send_byte(8'h00, 1'b0, 1'b1);
      s_valid = 1'b0;
      @(negedge clk);
      check("max_words_error", 32'(error),   32'd0);
      check("max_words_ready", 32'(s_ready), 32'd1);
      @(posedge clk); #1;

      // Reset two bytes into word 1: word 0 written, word 1 dropped.
      do_reset();
      model_reset();
      pulse_start();
      for (int k = 0; k < 10; k++)
         send_byte(tbl[0].bytes[127 - 8*k -: 8], 1'b0, 1'b1);
      s_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midword_writes", 32'(we_count), 32'd1);
      check_reset_outputs("midword_rst");
      repeat (3) @(posedge clk); #1;
      check("midword_no_late_we", 32'(we_count), 32'd1);
      run_vector(0, 1'b0);

      // After DONE: start and a valid stream are ignored.
      s_valid = 1'b1;
      s_data  = 8'h55;
      pulse_start();
      repeat (4) begin
         @(negedge clk);
         check("after_done_s_ready", 32'(s_ready), 32'd0);
         check("after_done_done",    32'(done),    32'd1);
         @(posedge clk); #1;
      end
      check("after_done_writes", 32'(we_count), 32'd2);
      s_valid = 1'b0;

      // After ERR: same, no writes and core stays in reset.
      run_vector(3, 1'b1);
      s_valid = 1'b1;
      s_data  = 8'h12;
      pulse_start();
      repeat (4) begin
         @(negedge clk);
         check("after_err_s_ready", 32'(s_ready), 32'd0);
         check("after_err_cpu_rst", 32'(cpu_rst), 32'd1);
         @(posedge clk); #1;
      end
      check("after_err_writes", 32'(we_count), 32'd0);
      s_valid = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
      for (int pass = 0; pass < 2; pass++) begin
         logic [63:0] img;
         img = 64'h00000001_11223344;
         do_reset();
         model_reset();
         pulse_start();
         for (int k = 0; k < 8; k++) send_byte(img[63 - 8*k -: 8], 1'b0, 1'b1);
         send_byte((pass == 0) ? 8'h45 : 8'h00, 1'b0, 1'b0);
         s_valid = 1'b0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         check(pass == 0 ? "csum_good_done" : "csum_bad_done", 32'(done), 32'(pass == 0));
         check(pass == 0 ? "csum_good_err" : "csum_bad_err", 32'(error), 32'(pass != 0));
         check(pass == 0 ? "csum_good_cpu_rst" : "csum_bad_cpu_rst", 32'(cpu_rst), 32'(pass != 0));
         check(pass == 0 ? "csum_good_writes" : "csum_bad_writes", 32'(we_count), 32'd1);
         @(posedge clk); #1;
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
